// File: rtl/ram_dma_pkg.sv
// Shared widths and state encoding for the ram_dma block-copy engine.
package ram_dma_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ram_dma.sv
// Block-copy engine driving a synchronous-read RAM port: RD/WR per word, done pulse at end.
// Optional fill feature (one WR per word of a constant) is enabled by defining RAM_DMA_FILL_EN.
module ram_dma #(
    parameter int ADDR_W = ram_dma_pkg::ADDR_W,
    parameter int DATA_W = ram_dma_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out
`ifdef RAM_DMA_FILL_EN
    ,
    input  logic              fill_mode,
    input  logic [DATA_W-1:0] fill_data
`endif
);

    import ram_dma_pkg::*;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   w_cnt_inc;
    logic              w_fill;
    logic              w_start_fill;

`ifdef RAM_DMA_FILL_EN
    logic              r_fill;
    logic [DATA_W-1:0] r_fill_data;

    assign w_fill       = r_fill;
    assign w_start_fill = fill_mode;
`else
    assign w_fill       = 1'b0;
    assign w_start_fill = 1'b0;
`endif

    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_src <= src;
                        r_dst <= dst;
                        r_len <= len;
                        r_cnt <= '0;
                    end
                end
                ST_WR: begin
                    r_src <= r_src + 1'b1;
                    r_dst <= r_dst + 1'b1;
                    r_cnt <= w_cnt_inc;
                end
                default: ;
            endcase
        end
    end

`ifdef RAM_DMA_FILL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill      <= 1'b0;
            r_fill_data <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_fill      <= fill_mode;
            r_fill_data <= fill_data;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0)
                        w_state_next = ST_DONE;
                    else
                        w_state_next = w_start_fill ? ST_WR : ST_RD;
                end
            end
            ST_RD:   w_state_next = ST_WR;
            ST_WR: begin
                // Count compares at full width so len=256 ends after the 256th word.
                if (w_cnt_inc == r_len)
                    w_state_next = ST_DONE;
                else
                    w_state_next = w_fill ? ST_WR : ST_RD;
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        ram_address = '0;
        ram_in      = '0;
        ram_load    = 1'b0;
        case (r_state)
            ST_RD: begin
                busy        = 1'b1;
                ram_address = r_src;
            end
            ST_WR: begin
                busy        = 1'b1;
                ram_address = r_dst;
                ram_load    = 1'b1;
`ifdef RAM_DMA_FILL_EN
                ram_in      = r_fill ? r_fill_data : ram_out;
`else
                ram_in      = ram_out;
`endif
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_dma.sv
// Scoreboard bench for ram_dma with a behavioural 256x16 synchronous-read RAM as responder.
module tb_ram_dma;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  src = '0;
    logic [7:0]  dst = '0;
    logic [8:0]  len = '0;
    logic        busy;
    logic        done;
    logic [7:0]  ram_address;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [15:0] ram_out;
`ifdef RAM_DMA_FILL_EN
    logic        fill_mode = 1'b0;
    logic [15:0] fill_data = '0;
`endif

    logic        tb_we = 1'b0;
    logic [7:0]  tb_addr = '0;
    logic [15:0] tb_data = '0;
    logic [15:0] mem   [256];
    logic [15:0] model [256];

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    ram_dma dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
        .busy(busy), .done(done), .ram_address(ram_address), .ram_in(ram_in),
        .ram_load(ram_load), .ram_out(ram_out)
`ifdef RAM_DMA_FILL_EN
        , .fill_mode(fill_mode), .fill_data(fill_data)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_load)
            mem[ram_address] <= ram_in;
        else if (tb_we)
            mem[tb_addr] <= tb_data;
        ram_out <= mem[ram_address];
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Monitor: every DUT write must match the next expected write.
    always @(negedge clk) begin
        if (rst_n && ram_load) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: addr %0h data %0h, required no write", ram_address, ram_in);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", longint'(ram_address), longint'(e.addr));
                check("write_data", longint'(ram_in), longint'(e.data));
                $display("write addr=%02h data=%04h", ram_address, ram_in);
            end
        end
    end

    task automatic poke_mem(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(posedge clk);
        #1 tb_we = 1'b0;
        model[a] = d;
    endtask

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== model[i]) n++;
        return n;
    endfunction

    task automatic run_xfer(input string name, input logic [7:0] s, input logic [7:0] d,
                            input logic [8:0] n, input bit fill, input logic [15:0] fdata,
                            input bit poke);
        int cyc = 0, busy_cyc = 0, rd_cyc = 0, exp_cyc;
        bit got_done = 0;
        exp_cyc = fill ? int'(n) : 2 * int'(n);
        for (int k = 0; k < int'(n); k++) begin
            logic [7:0]  sa = s + 8'(k);
            logic [7:0]  da = d + 8'(k);
            logic [15:0] wd = fill ? fdata : model[sa];
            model[da] = wd;
            exp_q.push_back({da, wd});
        end
        @(negedge clk);
        start = 1'b1; src = s; dst = d; len = n;
`ifdef RAM_DMA_FILL_EN
        fill_mode = fill; fill_data = fdata;
`endif
        @(posedge clk);
        #1 start = 1'b0;
        while (!got_done && cyc < 1000) begin
            if (done) got_done = 1;
            else begin
                if (busy) busy_cyc++;
                if (busy && !ram_load) rd_cyc++;
            end
            if (!got_done) begin
                if (poke && cyc == 100) begin
                    start = 1'b1; src = 8'h55; dst = 8'h99; len = 9'd1;
                end else if (poke && cyc == 101) begin
                    start = 1'b0;
                end
                @(posedge clk);
                #1 cyc++;
            end
        end
        check({name, "_done_seen"}, longint'(got_done), 1);
        check({name, "_done_cycle"}, cyc, exp_cyc);
        check({name, "_busy_cycles"}, busy_cyc, exp_cyc);
        check({name, "_rd_cycles"}, rd_cyc, fill ? 0 : int'(n));
        check({name, "_busy_at_done"}, longint'(busy), 0);
        @(posedge clk);
        #1 check({name, "_done_one_cycle"}, longint'(done), 0);
        check({name, "_queue_drained"}, exp_q.size(), 0);
        check({name, "_ram_contents"}, mem_diffs(), 0);
        $display("xfer %s src=%02h dst=%02h len=%0d done_after=%0d", name, s, d, n, cyc);
    endtask

    initial begin
        #1;
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_load", longint'(ram_load), 0);
        check("rst_addr", longint'(ram_address), 0);
        check("rst_in", longint'(ram_in), 0);
        for (int i = 0; i < 256; i++) poke_mem(8'(i), 16'(i));
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Full-RAM self copy with a start pulse landing mid-transfer.
        run_xfer("len256", 8'h00, 8'h00, 9'd256, 1'b0, 16'h0, 1'b1);

        for (int i = 0; i < 4; i++) poke_mem(8'h10 + 8'(i), 16'hA001 + 16'(i));
        run_xfer("copy4", 8'h10, 8'h80, 9'd4, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 4; i++)
            check("copy4_word", longint'(mem[8'h80 + i]), longint'(16'hA001 + i));

        run_xfer("len0", 8'h33, 8'h44, 9'd0, 1'b0, 16'h0, 1'b0);

        poke_mem(8'hFE, 16'h1111); poke_mem(8'hFF, 16'h2222); poke_mem(8'h00, 16'h3333);
        run_xfer("wrap", 8'hFE, 8'h01, 9'd3, 1'b0, 16'h0, 1'b0);
        check("wrap_w0", longint'(mem[1]), 16'h1111);
        check("wrap_w1", longint'(mem[2]), 16'h2222);
        check("wrap_w2", longint'(mem[3]), 16'h3333);

        // Reset during the third WR of an 8-word copy.
        for (int i = 0; i < 8; i++) begin
            poke_mem(8'h40 + 8'(i), 16'h4000 + 16'(i));
            poke_mem(8'h60 + 8'(i), 16'h6000 + 16'(i));
        end
        exp_q.push_back({8'h60, 16'h4000});
        exp_q.push_back({8'h61, 16'h4001});
        model[8'h60] = 16'h4000;
        model[8'h61] = 16'h4001;
        @(negedge clk);
        start = 1'b1; src = 8'h40; dst = 8'h60; len = 9'd8;
`ifdef RAM_DMA_FILL_EN
        fill_mode = 1'b0;
`endif
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("rst_mid_in_wr", longint'(busy & ram_load), 1);
        rst_n = 1'b0;
        #1 check("rst_mid_load_low", longint'(ram_load), 0);
        begin
            int done_seen = 0;
            repeat (3) begin
                @(posedge clk);
                #1 if (done) done_seen++;
            end
            @(negedge clk) rst_n = 1'b1;
            repeat (3) begin
                @(posedge clk);
                #1 if (done || busy) done_seen++;
            end
            check("rst_mid_no_done_idle", done_seen, 0);
        end
        begin
            int changed = 0;
            for (int i = 0; i < 8; i++)
                if (mem[8'h60 + i] !== 16'h6000 + 16'(i)) changed++;
            check("rst_mid_changed_words", changed, 2);
        end
        check("rst_mid_queue_drained", exp_q.size(), 0);
        $display("xfer rst_mid src=40 dst=60 len=8 aborted");

`ifdef RAM_DMA_FILL_EN
        run_xfer("fill5", 8'h00, 8'h20, 9'd5, 1'b1, 16'hBEEF, 1'b0);
        for (int i = 0; i < 5; i++)
            check("fill5_word", longint'(mem[8'h20 + i]), 16'hBEEF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
